mem_byte_ctrl: RTL and testbench

Memory-side requester for the pipeline stall protocol. It takes one load or store from the MEM stage and serialises it onto the 8-bit synchronous RAM port, one byte per cycle, little-endian. It holds `stallreq_mem` high until the transfer completes, so the stall controller freezes PC through MEM. It then presents load data for exactly one cycle while the pipeline advances.

---
 rtl/mem_byte_ctrl_pkg.sv | 30 +++
 rtl/mem_byte_ctrl_if.sv | 35 +++
 rtl/mem_byte_ctrl_load_ext.sv | 28 ++
 rtl/mem_byte_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_byte_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_byte_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_byte_ctrl_pkg
// Shared definitions for the byte-serial memory requester: access-size
// encodings, FSM state encodings and a helper that turns a size code into a
// byte count.
// Ports: none (package).
// ----------------------------------------------------------------------------
package mem_byte_ctrl_pkg;

  // Access size encodings carried on the size field (3 behaves as a word).
  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    MEMC_IDLE = 2'd0,
    MEMC_XFER = 2'd1,
    MEMC_DONE = 2'd2
  } memc_state_e;

  // Number of bytes moved for a size code: 1, 2 or 4.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: return 3'd1;
      MEM_SIZE_H: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_byte_ctrl_if
// Request/response bus between the MEM pipeline stage and the byte-serial
// memory requester.
// Signals:
//   req, we, size, ld_unsigned, addr, wdata : operation from the MEM stage
//   rdata                                   : extended load result
//   stallreq_mem                            : stall request to the pipeline
// Modports: master = MEM stage side, slave = requester side.
// ----------------------------------------------------------------------------
interface mem_byte_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  import mem_byte_ctrl_pkg::*;

  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              ld_unsigned;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              stallreq_mem;

  modport master (
    output req, we, size, ld_unsigned, addr, wdata,
    input  rdata, stallreq_mem
  );

  modport slave (
    input  req, we, size, ld_unsigned, addr, wdata,
    output rdata, stallreq_mem
  );

endinterface

// File: rtl/mem_byte_ctrl_load_ext.sv
// ----------------------------------------------------------------------------
// load_ext
// Combinational size/sign extension of the assembled 32-bit load buffer.
// Ports:
//   raw         in  32 : little-endian assembled bytes (upper bytes may be stale)
//   size        in  2  : access size code
//   ld_unsigned in  1  : 1 = zero-extend, 0 = sign-extend
//   ext         out 32 : extended load value
// ----------------------------------------------------------------------------
module load_ext
  import mem_byte_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      MEM_SIZE_B: ext = {{24{~ld_unsigned & raw[7]}}, raw[7:0]};
      MEM_SIZE_H: ext = {{16{~ld_unsigned & raw[15]}}, raw[15:0]};
      default:    ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_byte_ctrl.sv
// ----------------------------------------------------------------------------
// mem_byte_ctrl
// Serialises one MEM-stage load/store onto an 8-bit synchronous RAM port,
// one byte per cycle, little-endian, while holding stallreq_mem high. Load
// data is registered and presented in the DONE cycle.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : mem_byte_ctrl_if.slave (req/we/size/ld_unsigned/addr/wdata
//                  in, rdata/stallreq_mem out)
//   mem_a        : RAM byte address
//   mem_dout     : RAM write byte
//   mem_wr       : RAM write strobe
//   mem_din      : RAM read byte, valid the cycle after its address
//   misaligned   : alignment-fault pulse (only with MEM_CTRL_ALIGN_CHECK_EN)
// Build option: define MEM_CTRL_ALIGN_CHECK_EN to reject misaligned half/word
// accesses instead of serialising them.
// ----------------------------------------------------------------------------
module mem_byte_ctrl
  import mem_byte_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_byte_ctrl_if.slave    bus,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din
`ifdef MEM_CTRL_ALIGN_CHECK_EN
  ,
  output logic              misaligned
`endif
);

  memc_state_e       state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [31:0]       byte_buf_reg;
  logic [31:0]       rdata_reg;

  logic [2:0]        n_bytes;
  logic [1:0]        cap_idx;
  logic [ADDR_W-1:0] addr_cnt;
  logic [7:0]        wbyte;
  logic [31:0]       assembled;
  logic [31:0]       ext_val;
  logic              fault;

  logic              capture;
  logic              load_done;
  logic              fault_pulse;
  logic              stall_c;
  logic              wr_c;
  logic [ADDR_W-1:0] a_c;
  logic [7:0]        dout_c;

  assign n_bytes  = size_bytes(bus.size);
  // In a load XFER cycle, cnt (1..4) names the byte after the one arriving.
  assign cap_idx  = cnt_reg[1:0] - 2'd1;
  assign addr_cnt = bus.addr + ADDR_W'(cnt_reg);
  assign wbyte    = bus.wdata[{cnt_reg[1:0], 3'b000} +: 8];

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  assign fault = ((bus.size == MEM_SIZE_H) && bus.addr[0]) ||
                 (bus.size[1] && (bus.addr[1:0] != 2'b00));
`else
  assign fault = 1'b0;
`endif

  // Merge the byte arriving this cycle into the buffer so the final byte is
  // visible to the extender on the same edge that enters DONE.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_assemble
      assign assembled[8*gi +: 8] =
        (capture && (cap_idx == 2'(gi))) ? mem_din : byte_buf_reg[8*gi +: 8];
    end
  endgenerate

  load_ext u_load_ext (
    .raw         (assembled),
    .size        (bus.size),
    .ld_unsigned (bus.ld_unsigned),
    .ext         (ext_val)
  );

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    capture     = 1'b0;
    load_done   = 1'b0;
    fault_pulse = 1'b0;
    stall_c     = 1'b0;
    wr_c        = 1'b0;
    a_c         = '0;
    dout_c      = '0;

    case (state_reg)
      MEMC_IDLE: begin
        if (bus.req) begin
          stall_c = 1'b1;
          if (fault) begin
            fault_pulse = 1'b1;
            state_next  = MEMC_DONE;
          end else begin
            a_c = bus.addr;
            if (bus.we) begin
              wr_c   = 1'b1;
              dout_c = bus.wdata[7:0];
            end
            if (bus.we && (n_bytes == 3'd1)) begin
              state_next = MEMC_DONE;
            end else begin
              cnt_next   = 3'd1;
              state_next = MEMC_XFER;
            end
          end
        end
      end

      MEMC_XFER: begin
        stall_c = 1'b1;
        // Termination uses >= so a protocol violation (operands changing
        // mid-transfer) still drains to IDLE within a few cycles.
        if (!bus.we) begin
          capture = 1'b1;
          if (cnt_reg < n_bytes) begin
            a_c      = addr_cnt;
            cnt_next = cnt_reg + 3'd1;
          end else begin
            load_done  = 1'b1;
            state_next = MEMC_DONE;
          end
        end else begin
          a_c    = addr_cnt;
          wr_c   = 1'b1;
          dout_c = wbyte;
          if (cnt_reg >= (n_bytes - 3'd1)) begin
            state_next = MEMC_DONE;
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
      end

      MEMC_DONE: begin
        cnt_next   = 3'd0;
        state_next = MEMC_IDLE;
      end

      default: begin
        cnt_next   = 3'd0;
        state_next = MEMC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= MEMC_IDLE;
      cnt_reg      <= 3'd0;
      byte_buf_reg <= '0;
      rdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        byte_buf_reg <= assembled;
      end
      if (load_done) begin
        rdata_reg <= ext_val;
      end
    end
  end

  // Reset forces every output low in the same cycle, which also blocks any
  // further write strobe from an aborted store.
  assign bus.stallreq_mem = rst ? 1'b0 : stall_c;
  assign bus.rdata        = rst ? 32'd0 : rdata_reg;
  assign mem_a            = rst ? '0 : a_c;
  assign mem_dout         = rst ? 8'd0 : dout_c;
  assign mem_wr           = rst ? 1'b0 : wr_c;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
  assign misaligned       = rst ? 1'b0 : fault_pulse;
`endif

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_byte_ctrl
// Self-checking bench for mem_byte_ctrl: directed loads/stores, back-to-back
// operations, reset abort, address wrap and randomized operations checked
// against a byte-array memory model.
// ----------------------------------------------------------------------------
module tb_mem_byte_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rdata = 32'd0;

  // RAM model: 4 KiB, addresses alias on the low 12 bits.
  logic [7:0]  ram [0:4095];
  bit          ram_ready = 1'b0;

  mem_byte_ctrl_if #(.ADDR_W(32)) bus_if ();

  mem_byte_ctrl #(.ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .mem_a    (mem_a),
    .mem_dout (mem_dout),
    .mem_wr   (mem_wr),
    .mem_din  (mem_din)
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    ,
    .misaligned (misaligned)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'(i * 37 + 11);
      ram_ready <= 1'b1;
    end else if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
    end
    mem_din <= ram[mem_a[11:0]];
  end

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  // Expected load value: read N bytes little-endian, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input bit uns);
    int          n;
    logic [31:0] v;
    logic [31:0] a;
    n = nbytes(size);
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      v = v | (32'(ram[a[11:0]]) << (8 * k));
    end
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  // Runs one operation starting in an IDLE cycle; returns at the DONE-cycle
  // negedge with req still high (so a following call is back-to-back).
  task automatic run_op(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int          n;
    int          exp_stall;
    int          k;
    bit          mis;
    bit          done;
    logic [31:0] exp_val;
    logic [31:0] a;
    logic [7:0]  wb;
    n   = nbytes(size);
    mis = 1'b0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    mis = (size == 2'd1 && addr[0]) || (size >= 2'd2 && addr[1:0] != 2'b00);
`endif
    exp_stall = mis ? 1 : (we ? n : n + 1);
    exp_val   = (we || mis) ? exp_rdata : model_load(addr, size, uns);

    @(posedge clk); #1;
    bus_if.req         = 1'b1;
    bus_if.we          = we;
    bus_if.size        = size;
    bus_if.ld_unsigned = uns;
    bus_if.addr        = addr;
    bus_if.wdata       = wdata;

    k    = 0;
    done = 1'b0;
    while (!done && k <= exp_stall + 3) begin
      @(negedge clk);
      if (bus_if.stallreq_mem !== 1'b1) begin
        done = 1'b1;
      end else begin
        a  = addr + 32'(k);
        wb = 8'(wdata >> (8 * k));
        checks++;
        if (bus_if.rdata !== exp_rdata) begin errors++; $display("FAIL rdata_hold cyc=%0d: got %08h expected %08h", k, bus_if.rdata, exp_rdata); end
        if (mis || k >= n) begin
          checks++;
          if (mem_wr !== 1'b0) begin errors++; $display("FAIL wr_quiet cyc=%0d: got %0b expected 0", k, mem_wr); end
        end else begin
          checks++;
          if (mem_a !== a) begin errors++; $display("FAIL mem_a cyc=%0d: got %08h expected %08h", k, mem_a, a); end
          checks++;
          if (mem_wr !== we) begin errors++; $display("FAIL mem_wr cyc=%0d: got %0b expected %0b", k, mem_wr, we); end
          if (we) begin
            checks++;
            if (mem_dout !== wb) begin errors++; $display("FAIL mem_dout cyc=%0d: got %02h expected %02h", k, mem_dout, wb); end
          end
        end
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        checks++;
        if (misaligned !== (mis && k == 0)) begin errors++; $display("FAIL misaligned cyc=%0d: got %0b expected %0b", k, misaligned, (mis && k == 0)); end
`endif
        k++;
        @(posedge clk); #1;
      end
    end

    checks++;
    if (!done) begin errors++; $display("FAIL done_timeout: stall still high after %0d cycles", k); end
    checks++;
    if (k != exp_stall) begin errors++; $display("FAIL stall_cycles: got %0d expected %0d", k, exp_stall); end
    checks++;
    if (bus_if.rdata !== exp_val) begin errors++; $display("FAIL rdata_done: got %08h expected %08h", bus_if.rdata, exp_val); end
    checks++;
    if (mem_wr !== 1'b0) begin errors++; $display("FAIL done_wr: got %0b expected 0", mem_wr); end
    if (we && !mis) begin
      for (int j = 0; j < n; j++) begin
        a  = addr + 32'(j);
        wb = 8'(wdata >> (8 * j));
        checks++;
        if (ram[a[11:0]] !== wb) begin errors++; $display("FAIL ram_byte %08h: got %02h expected %02h", a, ram[a[11:0]], wb); end
      end
    end
    exp_rdata = exp_val;
    $display("op we=%0d size=%0d uns=%0d addr=%08h wdata=%08h rdata=%08h stall=%0d mis=%0d",
             we, size, uns, addr, wdata, bus_if.rdata, k, mis);
  endtask

  // One IDLE cycle with req low and junk operands.
  task automatic idle_cycle();
    @(posedge clk); #1;
    bus_if.req   = 1'b0;
    bus_if.we    = 1'($urandom_range(0, 1));
    bus_if.addr  = $urandom;
    bus_if.wdata = $urandom;
    @(negedge clk);
    checks++;
    if (bus_if.stallreq_mem !== 1'b0) begin errors++; $display("FAIL idle_stall: got %0b expected 0", bus_if.stallreq_mem); end
    checks++;
    if (mem_wr !== 1'b0) begin errors++; $display("FAIL idle_wr: got %0b expected 0", mem_wr); end
    checks++;
    if (mem_a !== 32'd0 || mem_dout !== 8'd0) begin errors++; $display("FAIL idle_bus: got a=%08h d=%02h expected 0", mem_a, mem_dout); end
    checks++;
    if (bus_if.rdata !== exp_rdata) begin errors++; $display("FAIL idle_rdata: got %08h expected %08h", bus_if.rdata, exp_rdata); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus_if.req = 1'b1;
    bus_if.we  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.stallreq_mem !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got stall=%0b wr=%0b expected 0", bus_if.stallreq_mem, mem_wr); end
    checks++;
    if (mem_a !== 32'd0 || mem_dout !== 8'd0) begin errors++; $display("FAIL reset_bus: got a=%08h d=%02h expected 0", mem_a, mem_dout); end
    checks++;
    if (bus_if.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %08h expected 0", bus_if.rdata); end
    @(posedge clk); #1;
    rst        = 1'b0;
    bus_if.req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.stallreq_mem !== 1'b0 || bus_if.rdata !== 32'd0) begin errors++; $display("FAIL post_reset: got stall=%0b rdata=%08h expected 0", bus_if.stallreq_mem, bus_if.rdata); end
    exp_rdata = 32'd0;
    $display("reset released");
  endtask

  task automatic test_word_load();
    run_op(1'b1, 2'd2, 1'b0, 32'h100, 32'h8433_2211);
    idle_cycle();
    run_op(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    checks++;
    if (bus_if.rdata !== 32'h8433_2211) begin errors++; $display("FAIL word_load: got %08h expected 84332211", bus_if.rdata); end
    idle_cycle();
  endtask

  task automatic test_byte_load();
    run_op(1'b1, 2'd0, 1'b0, 32'h7, 32'h0000_0080);
    idle_cycle();
    run_op(1'b0, 2'd0, 1'b0, 32'h7, 32'd0);
    checks++;
    if (bus_if.rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL byte_load_s: got %08h expected ffffff80", bus_if.rdata); end
    idle_cycle();
    run_op(1'b0, 2'd0, 1'b1, 32'h7, 32'd0);
    checks++;
    if (bus_if.rdata !== 32'h0000_0080) begin errors++; $display("FAIL byte_load_u: got %08h expected 00000080", bus_if.rdata); end
    idle_cycle();
  endtask

  task automatic test_stores();
    run_op(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEAD_BEEF);
    idle_cycle();
    run_op(1'b1, 2'd0, 1'b0, 32'h205, 32'h1234_5678);
    idle_cycle();
    run_op(1'b1, 2'd3, 1'b0, 32'h208, 32'hCAFE_F00D);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 2'd2, 1'b0, 32'h200, 32'd0);
    run_op(1'b0, 2'd1, 1'b0, 32'h202, 32'd0);
    checks++;
    if (bus_if.rdata !== 32'hFFFF_DEAD) begin errors++; $display("FAIL b2b_half: got %08h expected ffffdead", bus_if.rdata); end
    run_op(1'b0, 2'd0, 1'b1, 32'h103, 32'd0);
    run_op(1'b1, 2'd1, 1'b0, 32'h210, 32'h0000_9A7C);
    run_op(1'b0, 2'd1, 1'b1, 32'h210, 32'd0);
    checks++;
    if (bus_if.rdata !== 32'h0000_9A7C) begin errors++; $display("FAIL b2b_store_load: got %08h expected 00009a7c", bus_if.rdata); end
    idle_cycle();
  endtask

  task automatic test_reset_mid_store();
    logic [7:0]  old2;
    logic [7:0]  old3;
    logic [31:0] wd;
    old2 = ram[12'h302];
    old3 = ram[12'h303];
    wd   = {~old3, ~old2, 8'h5A, 8'h3C};
    @(posedge clk); #1;
    bus_if.req   = 1'b1;
    bus_if.we    = 1'b1;
    bus_if.size  = 2'd2;
    bus_if.addr  = 32'h300;
    bus_if.wdata = wd;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.stallreq_mem !== 1'b0 || mem_wr !== 1'b0 || mem_a !== 32'd0 || mem_dout !== 8'd0 || bus_if.rdata !== 32'd0) begin
      errors++; $display("FAIL abort_outputs: got stall=%0b wr=%0b a=%08h d=%02h rdata=%08h expected all 0",
                         bus_if.stallreq_mem, mem_wr, mem_a, mem_dout, bus_if.rdata);
    end
    @(posedge clk); #1;
    rst        = 1'b0;
    bus_if.req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.stallreq_mem !== 1'b0 || mem_wr !== 1'b0 || bus_if.rdata !== 32'd0) begin errors++; $display("FAIL abort_idle: got stall=%0b wr=%0b rdata=%08h expected 0", bus_if.stallreq_mem, mem_wr, bus_if.rdata); end
    checks++;
    if (ram[12'h300] !== 8'h3C || ram[12'h301] !== 8'h5A) begin errors++; $display("FAIL abort_written: got %02h %02h expected 3c 5a", ram[12'h300], ram[12'h301]); end
    checks++;
    if (ram[12'h302] !== old2 || ram[12'h303] !== old3) begin errors++; $display("FAIL abort_unwritten: got %02h %02h expected %02h %02h", ram[12'h302], ram[12'h303], old2, old3); end
    exp_rdata = 32'd0;
    $display("reset during store: ram[300..303]=%02h %02h %02h %02h",
             ram[12'h300], ram[12'h301], ram[12'h302], ram[12'h303]);
    idle_cycle();
  endtask

  task automatic test_wrap_and_align();
    run_op(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'd0);
    run_op(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_B1A2);
    run_op(1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
    idle_cycle();
    run_op(1'b0, 2'd2, 1'b0, 32'h102, 32'd0);
    idle_cycle();
  endtask

  task automatic test_random();
    bit          we;
    bit          uns;
    logic [1:0]  size;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                         : 32'($urandom);
      run_op(we, size, uns, addr, 32'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();
  endtask

  initial begin
    bus_if.req         = 1'b0;
    bus_if.we          = 1'b0;
    bus_if.size        = 2'd0;
    bus_if.ld_unsigned = 1'b0;
    bus_if.addr        = 32'd0;
    bus_if.wdata       = 32'd0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_stores();
    test_back_to_back();
    test_reset_mid_store();
    test_wrap_and_align();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
